// File: rtl/core_fetch.sv
// core_fetch: RV32I instruction fetch stage.
// Holds the PC, issues word fetches to instruction memory, buffers in-order
// responses together with their PC, and hands them to core_decode through a
// valid/ready handshake. Redirects flush buffered work and discard in-flight
// responses through a drop counter.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_stall counters.
module core_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic [31:0] inst_pc
);

  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int AW     = $clog2(DEPTH);
  // The PC queue also holds entries of responses that will be dropped, so it
  // is twice the FIFO size: up to DEPTH live plus DEPTH stale requests.
  localparam int QW     = AW + 1;
  localparam int QDEPTH = 2 * DEPTH;
  localparam logic [CW:0] CREDITS = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  logic [31:0]   pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [QW-1:0] pq_wr;
  logic [QW-1:0] pq_rd;
  logic [31:0]   last_inst;
  logic [31:0]   last_pc;
  entry_t        fifo  [DEPTH];
  logic [31:0]   pc_q  [QDEPTH];

  logic [CW:0]   in_use;
  logic [CW:0]   drop_sum;
  logic [31:0]   redirect_aligned;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          pq_pop;
  logic          push;
  logic          pop;

  // Request credit, handshake decode and redirect target alignment.
  assign in_use           = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid   = !rst && !redirect_valid && (in_use < CREDITS);
  assign imem_addr        = pc;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign redirect_aligned = redirect_pc & ~32'h3;

  // A response retires the oldest PC-queue entry; it is discarded while stale
  // requests are pending and otherwise enters the FIFO unless a redirect hits.
  assign rsp_drop = imem_rsp_valid && (drop != '0);
  assign rsp_keep = imem_rsp_valid && (drop == '0) && (outstanding != '0);
  assign pq_pop   = rsp_drop || rsp_keep;
  assign push     = rsp_keep && !redirect_valid && !rst;
  assign pop      = inst_valid && dec_ready && !redirect_valid;

  // Everything still in flight at a redirect becomes stale; a response that
  // lands in the redirect cycle retires one of them immediately.
  assign drop_sum = {1'b0, drop} + {1'b0, outstanding} - (CW + 1)'(pq_pop);

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? fifo[rd_ptr].data : last_inst;
  assign inst_pc    = inst_valid ? fifo[rd_ptr].pc   : last_pc;

  // Control state: PC, occupancy counters and queue pointers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
      last_inst   <= '0;
      last_pc     <= '0;
    end else if (redirect_valid) begin
      pc          <= redirect_aligned;
      count       <= '0;
      wr_ptr      <= rd_ptr;
      outstanding <= '0;
      drop        <= drop_sum[CW-1:0];
      if (pq_pop) pq_rd <= pq_rd + QW'(1);
    end else begin
      if (req_fire) begin
        pc    <= pc + 32'd4;
        pq_wr <= pq_wr + QW'(1);
      end
      if (pq_pop) pq_rd <= pq_rd + QW'(1);
      if (rsp_drop) drop <= drop - CW'(1);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
      count       <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        last_inst <= fifo[rd_ptr].data;
        last_pc   <= fifo[rd_ptr].pc;
      end
    end
  end

  // Storage arrays for the FIFO and the PC queue.
  // NOTE: these memories carry no reset; count and the pointers decide which
  // entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push)     fifo[wr_ptr] <= '{data: imem_rsp_data, pc: pc_q[pq_rd]};
    if (req_fire) pc_q[pq_wr[QW-1:0]] <= pc;
  end

`ifdef FETCH_PERF_EN
  // Performance counters: decode handshakes and empty cycles out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (inst_valid && dec_ready) perf_fetched <= perf_fetched + 32'd1;
      if (!inst_valid)             perf_stall   <= perf_stall + 32'd1;
    end
  end
`else
  // Counters are absent in this build.
`endif

  // A response with nothing pending is a memory protocol violation.
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (outstanding == '0) && (drop == '0)));

  // The stale-request count must fit its register after a redirect.
  a_drop_fits: assert property (@(posedge clk) disable iff (rst)
    !(redirect_valid && drop_sum[CW]));

endmodule

// File: tb/tb_core_fetch.sv
// Self-checking bench for core_fetch (RESET_PC=0x1000, DEPTH=2).
// A memory model answers in order one cycle after acceptance and can be held;
// stimulus pushes expected decode entries and fetch addresses into queues,
// and a monitor compares them whenever the DUT presents a handshake.
module tb_core_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  core_fetch #(.RESET_PC(32'h0000_1000), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .inst_valid     (inst_valid),
    .inst           (inst),
`ifdef FETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .inst_pc        (inst_pc)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_req    = 0;
  int n_hs     = 0;
  int m_fetched = 0;
  int m_stall   = 0;
  bit mem_hold  = 1'b0;

  exp_t        exp_q  [$];
  logic [31:0] addr_q [$];
  mreq_t       mq     [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory content: each word encodes its own address.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[29:0], 2'b11};
  endfunction

  // Memory model: presents at most one in-order response per cycle.
  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (!mem_hold && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // Monitor: records accepted requests, checks addresses and decode output.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && imem_req_valid && imem_req_ready) begin
        mq.push_back('{addr: imem_addr, due: cyc + 1});
        n_req++;
        if (addr_q.size() > 0) check("imem_addr", imem_addr, addr_q.pop_front());
      end
      if (!rst && inst_valid && dec_ready && !redirect_valid) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_inst: actual pc=%h inst=%h required=none", inst_pc, inst);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("inst_pc", inst_pc, e.pc);
          check("inst", inst, e.data);
        end
      end
      if (rst) begin
        m_fetched = 0;
        m_stall   = 0;
      end else begin
        if (inst_valid && dec_ready) m_fetched++;
        if (!inst_valid)             m_stall++;
      end
      cyc++;
    end
  end

  // Accept exactly k sequential instructions starting at start_pc.
  task automatic consume(input logic [31:0] start_pc, input int k);
    int base;
    int budget;
    base   = n_hs;
    budget = 0;
    for (int i = 0; i < k; i++) begin
      logic [31:0] p;
      p = start_pc + 32'(4 * i);
      exp_q.push_back('{pc: p, data: mem_data(p)});
    end
    while ((n_hs - base) < k && budget < 200) begin
      @(negedge clk);
      dec_ready = ((n_hs - base) < k);
      budget++;
    end
    @(negedge clk);
    dec_ready = 1'b0;
    if ((n_hs - base) < k) begin
      checks++;
      failures++;
      $display("FAIL consume_timeout: actual=%0d required=%0d", n_hs - base, k);
    end
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Let all outstanding responses land in the FIFO without consuming.
  task automatic drain();
    dec_ready = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] target);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = target;
  endtask

  initial begin
    int base;
    rst            = 1'b1;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid",  32'(imem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst",       inst, 32'h0);
    check("rst_inst_pc",    inst_pc, 32'h0);
    check("rst_imem_addr",  imem_addr, 32'h0000_1000);

    // Startup fetch stream.
    addr_q.push_back(32'h0000_1000);
    addr_q.push_back(32'h0000_1004);
    addr_q.push_back(32'h0000_1008);
    rst = 1'b0;
    #1;
    check("req_after_rst", 32'(imem_req_valid), 32'd1);
    consume(32'h0000_1000, 3);

    // Decode stall: credits cap outstanding work at DEPTH.
    base = n_req;
    repeat (10) @(negedge clk);
    #1;
    check("stall_req_valid_low", 32'(imem_req_valid), 32'd0);
    check("stall_req_le_depth", 32'((n_req - base) <= 2), 32'd1);
    consume(32'h0000_100C, 4);

    // Redirect with two requests outstanding, then a second redirect.
    drain();
    redirect(32'h0000_3000);
    mem_hold = 1'b1;
    addr_q.push_back(32'h0000_3000);
    addr_q.push_back(32'h0000_3004);
    @(negedge clk);
    redirect_valid = 1'b0;
    base = n_req;
    repeat (5) @(negedge clk);
    #3;
    check("held_outstanding", 32'(n_req - base), 32'd2);
    check("held_inst_valid", 32'(inst_valid), 32'd0);
    redirect(32'h0000_2002);
    addr_q.push_back(32'h0000_2000);
    @(negedge clk);
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    consume(32'h0000_2000, 2);

    // Response arriving in the same cycle as a redirect.
    drain();
    redirect(32'h0000_4000);
    mem_hold = 1'b1;
    addr_q.push_back(32'h0000_4000);
    addr_q.push_back(32'h0000_4004);
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    redirect(32'h0000_5000);
    mem_hold = 1'b0;
    addr_q.push_back(32'h0000_5000);
    @(negedge clk);
    redirect_valid = 1'b0;
    consume(32'h0000_5000, 2);

    // PC wrap at the top of the address space.
    redirect(32'hFFFF_FFFC);
    addr_q.push_back(32'hFFFF_FFFC);
    addr_q.push_back(32'h0000_0000);
    @(negedge clk);
    redirect_valid = 1'b0;
    consume(32'hFFFF_FFFC, 2);
    check("addr_queue_drained", 32'(addr_q.size()), 32'd0);

`ifdef FETCH_PERF_EN
    @(negedge clk);
    #1;
    check("perf_fetched", perf_fetched, 32'(m_fetched));
    check("perf_stall",   perf_stall,   32'(m_stall));
`endif

    // Final reset returns the block to its initial state.
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    @(negedge clk);
    #1;
    check("rst2_inst_valid", 32'(inst_valid), 32'd0);
    check("rst2_req_valid",  32'(imem_req_valid), 32'd0);
    check("rst2_inst",       inst, 32'h0);
    check("rst2_imem_addr",  imem_addr, 32'h0000_1000);
`ifdef FETCH_PERF_EN
    check("rst2_perf_fetched", perf_fetched, 32'h0);
    check("rst2_perf_stall",   perf_stall, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
